// File: rtl/sprite_sequencer.sv
// sprite_sequencer: pixel strobes, storage shift control and post-clip resync.
// Define SPRITE_LOAD_EN to add the vblank-arbitrated host bitmap reload.
module sprite_sequencer #(
  parameter int WIDTH  = 12,
  parameter int HEIGHT = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       display_active,
  input  logic       vblank,
  input  logic [6:0] sprite_x,
  input  logic [6:0] sprite_y,
  output logic       new_line,
  output logic       sprite_access,
  output logic       sprite_visible,
  input  logic       display_shift,
  input  logic       storage_dout,
  output logic       storage_shift,
  output logic       storage_din,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic       load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic       load_error
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESYNC = 2'd1,
    ARMED  = 2'd2,
    LOAD   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, idle_cnt;
  logic [6:0]    sx_l, sy_l;
  logic [7:0]    dx, dy;
  logic          vblank_q, rise;
  logic          shift, din, clr;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
    return (c == LAST) ? '0 : c + 1'b1;
  endfunction

  assign rise = vblank & ~vblank_q;

  // Wrapping subtract: blocks left of / above the sprite read as huge.
  assign dx = {1'b0, x_pos[9:3]} - {1'b0, sx_l};
  assign dy = {1'b0, y_pos[9:3]} - {1'b0, sy_l};

  assign new_line       = (y_pos[2:0] == 3'd0);
  assign sprite_access  = (x_pos[2:0] == 3'd7) && display_active;
  assign sprite_visible = display_active &&
                          (dx < 8'(WIDTH)) && (dy < 8'(HEIGHT));

  assign idle_cnt      = display_shift ? inc(cnt) : cnt;
  assign storage_shift = shift & reset_n;
  assign storage_din   = din;
  assign cnt_nxt       = clr ? '0 : (shift ? inc(cnt) : cnt);

`ifdef SPRITE_LOAD_EN
  logic fall, done_nxt, err_nxt;
  assign fall = ~vblank & vblank_q;
`endif

  always_comb begin
    shift     = 1'b0;
    din       = storage_dout;
    clr       = 1'b0;
    state_nxt = state;
`ifdef SPRITE_LOAD_EN
    load_ready = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        shift = display_shift;
`ifdef SPRITE_LOAD_EN
        if (load_start)
          state_nxt = ARMED;
        else
`endif
        if (rise && idle_cnt != '0)
          state_nxt = RESYNC;
      end
      RESYNC: begin
        shift = 1'b1;
        if (cnt == LAST)
          state_nxt = IDLE;
      end
`ifdef SPRITE_LOAD_EN
      ARMED: begin
        shift = display_shift;
        if (rise) begin
          state_nxt = LOAD;
          clr       = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift = 1'b1;
          din   = load_data;
        end
        if (load_valid && cnt == LAST) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sx_l     <= '0;
      sy_l     <= '0;
      vblank_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vblank_q <= vblank;
      if (rise) begin
        sx_l <= sprite_x;
        sy_l <= sprite_y;
      end
    end
  end

`ifdef SPRITE_LOAD_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      load_done  <= done_nxt;
      load_error <= err_nxt;
    end
  end
`else
  logic unused_load;
  assign unused_load = ^{load_start, load_valid, load_data};
  assign load_ready  = 1'b0;
  assign load_done   = 1'b0;
  assign load_error  = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_sequencer.sv
// tb_sprite_sequencer: random stimulus, queue scoreboard for storage shifts.
// Storage register is modelled here; reload tests run when SPRITE_LOAD_EN is set.
module tb_sprite_sequencer;

  localparam int W = 12;
  localparam int H = 12;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic       display_active = 1'b0;
  logic       vblank = 1'b0;
  logic [6:0] sprite_x = '0;
  logic [6:0] sprite_y = '0;
  logic       new_line, sprite_access, sprite_visible;
  logic       display_shift = 1'b0;
  logic       storage_dout;
  logic       storage_shift, storage_din;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_data = 1'b0;
  logic       load_ready, load_done, load_error;

  sprite_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_pos(x_pos), .y_pos(y_pos),
    .display_active(display_active), .vblank(vblank),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .new_line(new_line), .sprite_access(sprite_access),
    .sprite_visible(sprite_visible),
    .display_shift(display_shift), .storage_dout(storage_dout),
    .storage_shift(storage_shift), .storage_din(storage_din),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Circular storage register the controller drives.
  logic [N-1:0] store;
  logic [N-1:0] seed;
  logic         init_done = 1'b0;
  assign storage_dout = store[0];
  always @(posedge clk) begin
    if (!init_done)
      store <= seed;
    else if (storage_shift)
      store <= {storage_din, store[N-1:1]};
  end

  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;
  int model_cnt = 0;
  int sx_m = 0;
  int sy_m = 0;
  bit mq[$];
  bit expq[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] mqvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mq[i];
    return v;
  endfunction

  task automatic recirc();
    bit b;
    b = mq.pop_front();
    mq.push_back(b);
    expq.push_back(b);
  endtask

  task automatic load_expect(input bit b);
    void'(mq.pop_front());
    mq.push_back(b);
    expq.push_back(b);
  endtask

  task automatic latch(input int sx, input int sy);
    step();
    sprite_x = 7'(sx);
    sprite_y = 7'(sy);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    sprite_x = 7'($urandom_range(0, 99));
    sprite_y = 7'($urandom_range(0, 74));
    sx_m = sx;
    sy_m = sy;
  endtask

  task automatic dec(input int x, input int y, input bit da,
                     input string nm);
    int bx, by;
    bit vis;
    step();
    x_pos = 10'(x);
    y_pos = 10'(y);
    display_active = da;
    smp();
    bx = x / 8;
    by = y / 8;
    vis = da && bx >= sx_m && bx < sx_m + W && by >= sy_m && by < sy_m + H;
    check({nm, "_vis"}, 32'(sprite_visible), 32'(vis));
    check({nm, "_acc"}, 32'(sprite_access), 32'((x % 8 == 7) && da));
    check({nm, "_nl"}, 32'(new_line), 32'(y % 8 == 0));
  endtask

  task automatic frame(input int k);
    int got = 0;
    int r;
    while (got < k) begin
      step();
      display_shift = ($urandom_range(0, 2) != 0);
      if (display_shift) begin
        recirc();
        got++;
        model_cnt = (model_cnt + 1) % N;
      end
    end
    step();
    display_shift = 1'b0;
    vblank = 1'b1;
    r = (model_cnt == 0) ? 0 : N - model_cnt;
    repeat (r) recirc();
    repeat (N + 4) step();
    vblank = 1'b0;
    smp();
    check("resync_left", 32'(expq.size()), 32'd0);
    check("resync_align", 32'(store == mqvec()), 32'd1);
    model_cnt = 0;
  endtask

`ifdef SPRITE_LOAD_EN
  task automatic reload(input int nbits, input bit simult, input bit rst);
    bit bits[$];
    logic [N-1:0] bv;
    int idx = 0;
    bit v;
    for (int i = 0; i < N; i++) bits.push_back(1'($urandom));
    if (simult) begin
      repeat (7) begin
        step();
        display_shift = 1'b1;
        recirc();
      end
      step();
      display_shift = 1'b0;
      load_start = 1'b1;
      vblank = 1'b1;
      step();
      load_start = 1'b0;
      vblank = 1'b0;
    end else begin
      step();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      repeat (9) begin
        step();
        display_shift = 1'b1;
        recirc();
      end
      step();
      display_shift = 1'b0;
    end
    smp();
    check("armed_ready", 32'(load_ready), 32'd0);
    step();
    vblank = 1'b1;
    load_valid = 1'b1;
    load_data = bits[0];
    smp();
    check("rise_ready", 32'(load_ready), 32'd0);
    while (idx < nbits) begin
      step();
      v = ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data = bits[idx];
      load_start = (idx == 5);
      if (v) begin
        load_expect(bits[idx]);
        idx++;
      end
      smp();
      check("load_ready", 32'(load_ready), 32'd1);
    end
    step();
    load_start = 1'b0;
    if (rst) begin
      reset_n = 1'b0;
      vblank = 1'b0;
      load_valid = 1'b1;
      load_data = 1'b1;
      step();
      smp();
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_error", 32'(load_error), 32'd0);
      check("rst_shift", 32'(storage_shift), 32'd0);
      step();
      reset_n = 1'b1;
      load_valid = 1'b0;
      sx_m = 0;
      sy_m = 0;
      dec(0, 0, 1'b1, "post_rst");
      check("rst_align", 32'(store == mqvec()), 32'd1);
    end else if (nbits == N) begin
      load_valid = 1'b0;
      smp();
      check("done_pulse", 32'(load_done), 32'd1);
      check("done_ready", 32'(load_ready), 32'd0);
      step();
      smp();
      check("done_clear", 32'(load_done), 32'd0);
      for (int i = 0; i < N; i++) bv[i] = bits[i];
      check("load_image", 32'(store == bv), 32'd1);
      step();
      vblank = 1'b0;
    end else begin
      load_valid = 1'b0;
      vblank = 1'b0;
      smp();
      check("abort_ready_hold", 32'(load_ready), 32'd1);
      check("abort_early", 32'(load_error), 32'd0);
      step();
      smp();
      check("abort_pulse", 32'(load_error), 32'd1);
      check("abort_ready", 32'(load_ready), 32'd0);
      step();
      smp();
      check("abort_clear", 32'(load_error), 32'd0);
      check("abort_keep", 32'(store == mqvec()), 32'd1);
    end
    model_cnt = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      seed[i] = 1'($urandom);
      mq.push_back(seed[i]);
    end
    repeat (2) step();
    smp();
    check("reset_ready", 32'(load_ready), 32'd0);
    check("reset_done", 32'(load_done), 32'd0);
    check("reset_error", 32'(load_error), 32'd0);
    check("reset_shift", 32'(storage_shift), 32'd0);
    step();
    reset_n = 1'b1;
    init_done = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (storage_shift === 1'b1) begin
          if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_shift: got 1 expected 0 at %0t", $time);
          end else begin
            check("shift_din", 32'(storage_din), 32'(expq.pop_front()));
          end
        end
        if (load_done === 1'b1) n_done++;
        if (load_error === 1'b1) n_err++;
      end
    join_none

    latch(1, 2);
    dec(15, 16, 1'b1, "dec_hit");
    dec(111, 16, 1'b1, "dec_right_out");
    dec(103, 104, 1'b1, "dec_corner_in");
    dec(103, 112, 1'b1, "dec_below_out");
    dec(7, 20, 1'b1, "dec_left_wrap");
    dec(15, 16, 1'b0, "dec_blank");
    dec(8, 17, 1'b1, "dec_mid");

    latch(95, 0);
    dec(792, 0, 1'b1, "clip_bx99");
    dec(0, 0, 1'b1, "clip_bx0");
    dec(760, 40, 1'b1, "clip_bx95");
    dec(752, 40, 1'b1, "clip_bx94");

    repeat (6) begin
      int sx, sy, x, y;
      sx = $urandom_range(0, 99);
      sy = $urandom_range(0, 74);
      latch(sx, sy);
      repeat (5) begin
        x = sx * 8 + $urandom_range(0, W * 8 + 32) - 16;
        y = sy * 8 + $urandom_range(0, H * 8 + 32) - 16;
        if (x < 0) x = 0;
        if (x > 799) x = 799;
        if (y < 0) y = 0;
        if (y > 599) y = 599;
        dec(x, y, 1'($urandom), "dec_rand");
      end
    end

    frame(100);
    frame(N);
    frame($urandom_range(1, N - 1));

`ifdef SPRITE_LOAD_EN
    reload(N, 1'b0, 1'b0);
    frame(57);
    reload(N, 1'b1, 1'b0);
    reload(50, 1'b0, 1'b0);
    frame(0);
    reload(20, 1'b0, 1'b1);
    frame($urandom_range(1, N - 1));
    check("done_count", 32'(n_done), 32'd2);
    check("error_count", 32'(n_err), 32'd1);
`else
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    vblank = 1'b1;
    load_valid = 1'b1;
    repeat (6) begin
      step();
      load_data = 1'($urandom);
      smp();
      check("noload_ready", 32'(load_ready), 32'd0);
      check("noload_done", 32'(load_done), 32'd0);
      check("noload_error", 32'(load_error), 32'd0);
    end
    step();
    vblank = 1'b0;
    load_valid = 1'b0;
    frame(33);
`endif

    repeat (3) step();
    check("final_left", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
